seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexing scan controller that shares one combinational BCD-to-seven-segment decoder among the four digits of a common-anode display. It holds a committed 4-digit BCD value and steps a digit index. For each slot it presents one nibble to the decoder's x3..x0 inputs and drives the matching active-low anode. New values load through a pulse handshake and commit only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot; legal range ≥ GUARD+2.
- GUARD, 4: cycles at the start of each slot with all anodes off (ghosting guard); legal range ≥ 0.
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- load  in  1  one-cycle request to update the displayed value.
- din  in  16  four BCD digits; din[3:0] is digit 0 (rightmost).
- dp_in  in  4  decimal-point enables per digit; active-high.
- lz_en  in  1  leading-zero suppression enable; sampled every cycle.
- dig_bcd  out  4  nibble to decoder: bit 3→x3 … bit 0→x0.
- an  out  4  anode selects; active-low, one-hot-low or all high.
- dp  out  1  decimal point; active-low.
- load_ack  out  1  one-cycle pulse when a pending load commits.
- frame_done  out  1  one-cycle pulse at the end of each 4-digit frame.

## Operation
- Registers:
  - active[15:0] and act_dp[3:0] hold the committed value.
  - pend[15:0], pend_dp[3:0] and pend_v hold the shadow copy.
  - idx[1:0] is the digit index.
  - cnt is the slot counter, width $clog2(REFRESH_DIV).
- Load rule: when load=1, din and dp_in are captured into the pend registers and pend_v is set. A second load before commit overwrites pend; the latest value wins, with no error.
- Scan order is 0,1,2,3,0 and so on, wrapping without gaps.
- Per slot:
  - dig_bcd = active[4*idx+:4].
  - dp = ~act_dp[idx], gated by the same condition as the anode.
  - an = 4'b1111 while cnt < GUARD.
  - Otherwise an = ~(1<<idx), unless the digit is blanked.
- Blanking applies in either of two cases:
  - The nibble is greater than 9 (invalid BCD). This applies even when lz_en=0.
  - lz_en=1, idx>0, and the digit plus every higher digit are all 0. Digit 0 is never suppressed by lz_en.
  - A blanked digit keeps an=4'b1111 and dp=1 for the whole slot.
- Commit: on the last cycle of the digit-3 slot (idx=3, cnt=REFRESH_DIV-1):
  - If pend_v=1, or load=1 in that same cycle, then active ← (load ? din : pend), pend_v clears, and load_ack pulses on the next cycle.
  - A load in the commit cycle bypasses pend and commits directly.

## Timing
- Reset values: idx=0, cnt=0, active=0, act_dp=0, pend=0, pend_v=0, an=4'b1111, dig_bcd=0, dp=1, load_ack=0, frame_done=0.
- All outputs are registered. an, dig_bcd and dp change only on the clock edge where cnt wraps, or where cnt reaches GUARD.
- Slot length is exactly REFRESH_DIV cycles. Frame length is 4·REFRESH_DIV cycles.
- frame_done and load_ack are high in the first cycle of the following digit-0 slot.
- Load-to-display latency ranges from 1 cycle (load in the commit cycle) up to 4·REFRESH_DIV cycles, plus the guard.
- Reset mid-frame: outputs return to reset values immediately (asynchronous), and any pending load is discarded. After rst deasserts, scanning restarts at idx=0, cnt=0.
- lz_en or dp_in changes mid-slot: lz_en takes effect at the next registered update. dp_in matters only through load.

## Structure
- Shared package seg_pkg:
  - NUM_DIGITS=4.
  - AN_OFF=4'b1111.
  - typedef digit_idx_t (2 bits).
  - BCD_MAX=4'd9.
- Sub-module scan_tick_gen (REFRESH_DIV, GUARD):
  - Outputs: slot_end, guard_active, cnt.
  - The parent owns idx, the load/commit logic and the output registers.
- The decoder is instantiated beside this block, not inside it. This keeps it reusable for single-digit use.

## Test plan
Run all scenarios with REFRESH_DIV=8, GUARD=2.
- Reset then idle, active=0, lz_en=0 → an cycles 1111,1111,1110×6 then 1111,1111,1101×6 and so on. dig_bcd=0 in every slot. frame_done pulses every 32 cycles.
- load din=16'h1234, dp_in=4'b0100 mid-frame → the display is unchanged until the frame ends. load_ack pulses with frame_done. Next frame: dig_bcd = 4,3,2,1, and dp=0 only during the digit-2 anode-on cycles.
- lz_en=1, active=16'h0070 → digits 3 and 2 are blanked (an=1111 for the whole slot). Digit 1 shows 7 and digit 0 shows 0. With active=0, only digit 0 is lit.
- active=16'h9A05 → digit 2 (A) is blanked with dp=1. Digits 3, 1 and 0 are lit.
- Two loads (16'h1111, then 16'h2222) in one frame, then a load of 16'h3333 exactly in the commit cycle → a single load_ack is produced and the next frame shows 3333.
- Assert rst at idx=2, cnt=5, with pend_v=1 → an=1111 and dig_bcd=0 immediately. After release, scanning restarts at digit 0 showing 0000, and no load_ack occurs.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants, types and helpers for the seven-segment scan controller.
package seg_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] AN_OFF     = 4'b1111;
    localparam logic [3:0] BCD_MAX    = 4'd9;

    typedef logic [1:0] digit_idx_t;

    // True when digit i and every more significant digit of v are zero.
    function automatic logic upper_zero(input logic [4*NUM_DIGITS-1:0] v,
                                        input digit_idx_t              i);
        logic z;
        z = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(i) && v[4*k +: 4] != 4'd0) begin
                z = 1'b0;
            end
        end
        return z;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load handshake and display-side signals of the scan controller.
interface seg_scan_ctrl_if;
    import seg_pkg::*;

    logic                    load;
    logic [4*NUM_DIGITS-1:0] din;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    lz_en;
    logic [3:0]              dig_bcd;
    logic [NUM_DIGITS-1:0]   an;
    logic                    dp;
    logic                    load_ack;
    logic                    frame_done;

    modport master (
        output load, din, dp_in, lz_en,
        input  dig_bcd, an, dp, load_ack, frame_done
    );

    modport slave (
        input  load, din, dp_in, lz_en,
        output dig_bcd, an, dp, load_ack, frame_done
    );

endinterface

// File: rtl/scan_tick_gen.sv
// Digit-slot timer: counts REFRESH_DIV cycles per slot and flags the
// leading guard window during which all anodes stay off.
module scan_tick_gen #(
    parameter  int REFRESH_DIV = 100000,
    parameter  int GUARD       = 4,
    localparam int CW          = $clog2(REFRESH_DIV)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          slot_end,
    output logic          guard_active,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] LAST    = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_W = CW'(GUARD);

    assign slot_end     = (cnt == LAST);
    assign guard_active = (cnt < GUARD_W);

    // Free-running slot counter, wraps to zero after the last slot cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (slot_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode scan controller. Holds a committed BCD value,
// steps the digit index each slot and drives one shared decoder nibble
// plus active-low anode and decimal point. Loads are shadowed and only
// committed at the frame boundary so a frame never mixes old and new digits.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 4
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_ctrl_if.slave bus
);

    localparam int            CW         = $clog2(REFRESH_DIV);
    localparam logic          GUARD_ON   = (GUARD > 0);
    localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD > 0) ? GUARD - 1 : 0);
    localparam digit_idx_t    LAST_IDX   = digit_idx_t'(NUM_DIGITS - 1);

    logic          slot_end;
    logic          guard_active;
    logic [CW-1:0] cnt;

    scan_tick_gen #(
        .REFRESH_DIV (REFRESH_DIV),
        .GUARD       (GUARD)
    ) u_tick (
        .clk          (clk),
        .rst          (rst),
        .slot_end     (slot_end),
        .guard_active (guard_active),
        .cnt          (cnt)
    );

    digit_idx_t              idx;
    logic [4*NUM_DIGITS-1:0] active;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic [4*NUM_DIGITS-1:0] pend;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_v;

    logic [NUM_DIGITS-1:0]   an_q;
    logic [3:0]              dig_q;
    logic                    dp_q;
    logic                    ack_q;
    logic                    fd_q;

    logic                    guard_end;
    logic                    frame_end;
    logic                    commit;
    logic                    upd;
    logic                    guard_nx;
    logic                    blank_nx;
    logic                    lit_nx;
    digit_idx_t              idx_nx;
    logic [3:0]              nib_nx;
    logic [4*NUM_DIGITS-1:0] active_nx;
    logic [NUM_DIGITS-1:0]   act_dp_nx;

    // Next-state view: outputs are computed from where idx/cnt/active will
    // be after this edge, so they line up with the slot they describe.
    always_comb begin
        guard_end = GUARD_ON && (cnt == GUARD_LAST);
        frame_end = slot_end && (idx == LAST_IDX);
        commit    = frame_end && (pend_v || bus.load);
        active_nx = active;
        act_dp_nx = act_dp;
        if (commit) begin
            active_nx = bus.load ? bus.din   : pend;
            act_dp_nx = bus.load ? bus.dp_in : pend_dp;
        end
        idx_nx   = slot_end ? idx + digit_idx_t'(1) : idx;
        guard_nx = slot_end ? GUARD_ON : (guard_active && !guard_end);
        upd      = slot_end || guard_end;
        nib_nx   = active_nx[{idx_nx, 2'b00} +: 4];
        blank_nx = (nib_nx > BCD_MAX) ||
                   (bus.lz_en && (idx_nx != '0) && upper_zero(active_nx, idx_nx));
        lit_nx   = !guard_nx && !blank_nx;
    end

    // Digit index, committed/shadow value and registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            active  <= '0;
            act_dp  <= '0;
            pend    <= '0;
            pend_dp <= '0;
            pend_v  <= 1'b0;
            an_q    <= AN_OFF;
            dig_q   <= '0;
            dp_q    <= 1'b1;
            ack_q   <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            idx    <= idx_nx;
            active <= active_nx;
            act_dp <= act_dp_nx;
            if (commit) begin
                pend_v <= 1'b0;
            end else if (bus.load) begin
                pend    <= bus.din;
                pend_dp <= bus.dp_in;
                pend_v  <= 1'b1;
            end
            ack_q <= commit;
            fd_q  <= frame_end;
            // Display only moves at slot wrap and at guard release, so
            // lz_en changes land at the next of those edges.
            if (upd) begin
                an_q  <= lit_nx ? ~(4'b0001 << idx_nx) : AN_OFF;
                dp_q  <= lit_nx ? ~act_dp_nx[idx_nx] : 1'b1;
                dig_q <= nib_nx;
            end
        end
    end

    assign bus.an         = an_q;
    assign bus.dig_bcd    = dig_q;
    assign bus.dp         = dp_q;
    assign bus.load_ack   = ack_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with an 8-cycle slot and 2-cycle guard.
module tb_seg_scan_ctrl;
    import seg_pkg::*;

    localparam int RD = 8;
    localparam int GD = 2;
    localparam logic [3:0] ON_AN [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    seg_scan_ctrl_if bus();

    seg_scan_ctrl #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks ncyc cycles of slot s starting at its first cycle; optionally
    // pulses load at cycle ld_c of the slot.
    task automatic check_slot(input string tag, input int s, input logic [3:0] bcd,
                              input bit lit, input bit dp_low, input bit fd, input bit ack,
                              input int ncyc = RD, input int ld_c = -1,
                              input logic [15:0] ld_v = 16'h0, input logic [3:0] ld_dp = 4'h0);
        logic [3:0] exp_an;
        logic       exp_dp;
        for (int c = 0; c < ncyc; c++) begin
            exp_an = (c < GD || !lit) ? 4'b1111 : ON_AN[s];
            exp_dp = (c >= GD && lit && dp_low) ? 1'b0 : 1'b1;
            chk($sformatf("%s.s%0d.c%0d.an", tag, s, c), 16'(bus.an), 16'(exp_an));
            chk($sformatf("%s.s%0d.c%0d.bcd", tag, s, c), 16'(bus.dig_bcd), 16'(bcd));
            chk($sformatf("%s.s%0d.c%0d.dp", tag, s, c), 16'(bus.dp), 16'(exp_dp));
            chk($sformatf("%s.s%0d.c%0d.fd", tag, s, c), 16'(bus.frame_done),
                16'((c == 0) ? fd : 1'b0));
            chk($sformatf("%s.s%0d.c%0d.ack", tag, s, c), 16'(bus.load_ack),
                16'((c == 0) ? ack : 1'b0));
            if (c == ld_c) begin
                bus.load  = 1'b1;
                bus.din   = ld_v;
                bus.dp_in = ld_dp;
            end
            step();
            bus.load = 1'b0;
        end
    endtask

    task automatic check_frame(input string tag, input logic [15:0] v, input logic [3:0] lit,
                               input logic [3:0] dpl, input bit fd, input bit ack,
                               input int ld_s = -1, input int ld_c = -1,
                               input logic [15:0] ld_v = 16'h0, input logic [3:0] ld_dp = 4'h0);
        for (int s = 0; s < 4; s++) begin
            check_slot(tag, s, v[4*s +: 4], lit[s], dpl[s],
                       (s == 0) ? fd : 1'b0, (s == 0) ? ack : 1'b0,
                       RD, (s == ld_s) ? ld_c : -1, ld_v, ld_dp);
        end
    endtask

    initial begin
        bus.load  = 1'b0;
        bus.din   = 16'h0;
        bus.dp_in = 4'h0;
        bus.lz_en = 1'b0;
        rst       = 1'b1;
        repeat (3) step();
        chk("rst.an",  16'(bus.an), 16'h000F);
        chk("rst.bcd", 16'(bus.dig_bcd), 16'h0);
        chk("rst.dp",  16'(bus.dp), 16'h1);
        chk("rst.ack", 16'(bus.load_ack), 16'h0);
        chk("rst.fd",  16'(bus.frame_done), 16'h0);
        rst = 1'b0;

        // Idle frame; load 1234 mid-frame must not disturb it.
        check_frame("idle", 16'h0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1, 3, 16'h1234, 4'b0100);

        // 1234 shows with dp on digit 2; queue 0070 and enable lz before digit 3.
        check_slot("f1234", 0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b1, RD, 5, 16'h0070, 4'b0000);
        check_slot("f1234", 1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        check_slot("f1234", 2, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.lz_en = 1'b1;
        check_slot("f1234", 3, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);

        check_frame("lz0070", 16'h0070, 4'b0011, 4'b0000, 1'b1, 1'b1, 1, 3, 16'h0000, 4'b0000);
        check_frame("lz0000", 16'h0000, 4'b0001, 4'b0000, 1'b1, 1'b1, 2, 6, 16'h9A05, 4'b0100);
        bus.lz_en = 1'b0;

        // 9A05: digit 2 invalid and blanked even with its dp enabled.
        // Loads 1111, 2222, then 3333 in the commit cycle.
        check_slot("inv", 0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, RD, 4, 16'h1111, 4'b0000);
        check_slot("inv", 1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_slot("inv", 2, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0, RD, 3, 16'h2222, 4'b0000);
        check_slot("inv", 3, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, RD, 7, 16'h3333, 4'b0000);

        check_frame("q3333", 16'h3333, 4'b1111, 4'b0000, 1'b1, 1'b1);

        // No second ack; queue 5555 then reset at idx=2, cnt=5.
        check_slot("pre", 0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        check_slot("pre", 1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, RD, 3, 16'h5555, 4'b1111);
        check_slot("pre", 2, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 5);
        chk("pre.c5.an", 16'(bus.an), 16'h000B);
        rst = 1'b1;
        #1;
        chk("async.an",  16'(bus.an), 16'h000F);
        chk("async.bcd", 16'(bus.dig_bcd), 16'h0);
        chk("async.dp",  16'(bus.dp), 16'h1);
        step();
        step();
        rst = 1'b0;

        check_frame("post", 16'h0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
        check_slot("post2", 0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
